// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_arbiter
// Description : Shares the single write port and single read select of a
//               small register file between NUM_CLIENTS requesters. The write
//               and read channels each have their own round-robin arbiter
//               with registered grants. Read data comes back through a
//               registered path, with write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    // write channel
    input  logic [NUM_CLIENTS-1:0]            wr_req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_CLIENTS-1:0]            wr_gnt,
    // read channel
    input  logic [NUM_CLIENTS-1:0]            rd_req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_CLIENTS-1:0]            rd_gnt,
    output logic [NUM_CLIENTS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]             rd_data,
    // register file pins
    output logic                              rf_we,
    output logic [ADDR_WIDTH-1:0]             rf_waddr,
    output logic [DATA_WIDTH-1:0]             rf_wdata,
    output logic [ADDR_WIDTH-1:0]             rf_rsel,
    input  logic [DATA_WIDTH-1:0]             rf_rdata
);

    // Pointer width; at least one bit so a single-client build stays legal.
    localparam int c_PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    // ------------------------------------------------------------------------
    // Per-client address/data slices, unpacked for indexed selection.
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_wr_addr_a [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0] w_wr_data_a [NUM_CLIENTS];
    logic [ADDR_WIDTH-1:0] w_rd_addr_a [NUM_CLIENTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign w_wr_addr_a[gi] = wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wr_data_a[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_rd_addr_a[gi] = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Wrap a (pointer + offset) sum back into 0..NUM_CLIENTS-1. The sum never
    // exceeds 2*NUM_CLIENTS-2, so a single conditional subtract is enough.
    // ------------------------------------------------------------------------
    function automatic logic [c_PTR_W-1:0] f_wrap(input logic [c_PTR_W:0] i_sum);
        logic [c_PTR_W:0] v_sum;
        v_sum = i_sum;
        if (v_sum >= (c_PTR_W+1)'(NUM_CLIENTS)) begin
            v_sum = v_sum - (c_PTR_W+1)'(NUM_CLIENTS);
        end
        return v_sum[c_PTR_W-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Round-robin pick: the first requester at or after i_ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win last.
    // Result is {found, index}.
    // ------------------------------------------------------------------------
    function automatic logic [c_PTR_W:0] f_pick(
        input logic [NUM_CLIENTS-1:0] i_req,
        input logic [c_PTR_W-1:0]     i_ptr
    );
        logic               v_found;
        logic [c_PTR_W-1:0] v_win;
        logic [c_PTR_W-1:0] v_idx;
        v_found = 1'b0;
        v_win   = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            v_idx = f_wrap({1'b0, i_ptr} + (c_PTR_W+1)'(k));
            if (i_req[v_idx]) begin
                v_found = 1'b1;
                v_win   = v_idx;
            end
        end
        return {v_found, v_win};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [NUM_CLIENTS-1:0] r_wr_gnt;
    logic [NUM_CLIENTS-1:0] r_rd_gnt;
    logic [NUM_CLIENTS-1:0] r_rd_valid;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_waddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [ADDR_WIDTH-1:0]  r_rsel;
    logic                   r_rd_pend;
    logic [c_PTR_W-1:0]     r_rd_tag;

    // ------------------------------------------------------------------------
    // Combinational arbitration results
    // ------------------------------------------------------------------------
    logic                   w_wr_any;
    logic [c_PTR_W-1:0]     w_wr_win;
    logic                   w_rd_any;
    logic [c_PTR_W-1:0]     w_rd_win;
    logic [DATA_WIDTH-1:0]  w_capture;
    logic                   w_fwd_hit;

    // Select the write and read winners from the current pointers.
    always_comb begin
        {w_wr_any, w_wr_win} = f_pick(wr_req, r_wr_ptr);
        {w_rd_any, w_rd_win} = f_pick(rd_req, r_rd_ptr);
    end

    // The regfile commits the pending write on the capture edge, so its read
    // port still shows the old value; bypass with the in-flight write data.
    always_comb begin
        w_fwd_hit = r_we && (r_waddr == r_rsel);
        w_capture = w_fwd_hit ? r_wdata : rf_rdata;
    end

    // Write channel: register the winner's strobe, address, data and grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_wr_gnt <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else if (w_wr_any) begin
            r_we     <= 1'b1;
            r_waddr  <= w_wr_addr_a[w_wr_win];
            r_wdata  <= w_wr_data_a[w_wr_win];
            r_wr_gnt <= NUM_CLIENTS'(1) << w_wr_win;
            r_wr_ptr <= f_wrap({1'b0, w_wr_win} + (c_PTR_W+1)'(1));
        end else begin
            r_we     <= 1'b0;
            r_wr_gnt <= '0;
        end
    end

    // Read channel: register the winner's select and remember whose read it is.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr  <= '0;
            r_rd_gnt  <= '0;
            r_rsel    <= '0;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= '0;
        end else if (w_rd_any) begin
            r_rsel    <= w_rd_addr_a[w_rd_win];
            r_rd_gnt  <= NUM_CLIENTS'(1) << w_rd_win;
            r_rd_pend <= 1'b1;
            r_rd_tag  <= w_rd_win;
            r_rd_ptr  <= f_wrap({1'b0, w_rd_win} + (c_PTR_W+1)'(1));
        end else begin
            r_rd_gnt  <= '0;
            r_rd_pend <= 1'b0;
        end
    end

    // Read capture: one edge after the grant, latch data and pulse valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else if (r_rd_pend) begin
            r_rd_valid <= NUM_CLIENTS'(1) << r_rd_tag;
            r_rd_data  <= w_capture;
        end else begin
            r_rd_valid <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wr_gnt   = r_wr_gnt;
    assign rd_gnt   = r_rd_gnt;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign rf_rsel  = r_rsel;

endmodule
`default_nettype wire

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the two-register, 8-bit register file's single write port and single read select between NUM_CLIENTS requesters (e.g. ALU writeback, load unit, debug port).
- Write and read channels each use an independent round-robin arbiter with registered grants.
- Reads return through a registered data path, with write-to-read forwarding.
- Sits directly between the client blocks and the regfile's we/waddr/wdata/rsel/rdata pins.

Parameters:
- NUM_CLIENTS, 2, number of requesters (2..8).
- DATA_WIDTH, 8, regfile data width.
- ADDR_WIDTH, 1, regfile address width (2 registers).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_req  input  NUM_CLIENTS  per-client write request; held until granted.
- wr_addr  input  NUM_CLIENTS*ADDR_WIDTH  per-client write address; client i uses slice i.
- wr_data  input  NUM_CLIENTS*DATA_WIDTH  per-client write data; client i uses slice i.
- wr_gnt  output  NUM_CLIENTS  one-hot, one-cycle write grant pulse.
- rd_req  input  NUM_CLIENTS  per-client read request; held until granted.
- rd_addr  input  NUM_CLIENTS*ADDR_WIDTH  per-client read address.
- rd_gnt  output  NUM_CLIENTS  one-hot, one-cycle read grant pulse.
- rd_valid  output  NUM_CLIENTS  one-hot pulse marking rd_data valid for that client.
- rd_data  output  DATA_WIDTH  read result, shared by all clients.
- rf_we  output  1  to regfile we.
- rf_waddr  output  ADDR_WIDTH  to regfile waddr.
- rf_wdata  output  DATA_WIDTH  to regfile wdata.
- rf_rsel  output  ADDR_WIDTH  to regfile rsel.
- rf_rdata  input  DATA_WIDTH  from regfile rdata; combinational from rf_rsel.

Behaviour:
- Reset: on any edge with reset=0:
  - wr_gnt, rd_gnt, rd_valid, rf_we, rf_waddr, rf_wdata, rf_rsel and rd_data all go to 0.
  - Both round-robin pointers return to client 0.
  - Any in-flight read is discarded; no rf_we or rd_valid appears after a reset edge.
- Write arbitration, edge E:
  - If any wr_req bit is 1, choose the winner: the first requesting client at or after wr_ptr, wrapping modulo NUM_CLIENTS.
  - Register rf_we=1, rf_waddr and rf_wdata from the winner's slices, and wr_gnt[winner]=1.
  - Set wr_ptr = (winner+1) mod NUM_CLIENTS.
  - With no request, rf_we=0, wr_gnt=0, and the pointer holds.
- Write timing: the regfile commits at edge E+1. Latency is one cycle from the sampled request to the write strobe. Maximum throughput is one write per cycle.
- Read arbitration, edge E: same algorithm with rd_ptr. Register rf_rsel = winner's address, rd_gnt[winner]=1, and an internal pending-tag = winner.
- Read capture, edge E+1, when a read is pending:
  - Load rd_data with rf_rdata and pulse rd_valid[tag]=1 for one cycle.
  - Read latency is 2 edges from the request.
  - rd_data holds its value until the next capture.
- Forwarding: if at capture edge E+1 rf_we=1 and rf_waddr==rf_rsel, rd_data loads rf_wdata instead of rf_rdata, because the regfile still shows the old value.
- Handshake:
  - A client must hold req, addr and data stable until it sees its gnt.
  - A req bit still high on the edge that ends a gnt cycle counts as a new request.
  - A client deasserting req before it is granted withdraws the request; nothing is written.
- Simultaneous events:
  - The read and write channels are independent; both may grant in the same cycle, to the same or different clients.
  - Back-to-back reads pipeline, one per cycle.
- With NUM_CLIENTS=1, the block degenerates to a registered pass-through with the same latencies.
- Out-of-range pointer states cannot arise; pointer arithmetic wraps explicitly.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_req=2'b11 -> all outputs 0 and no grants. Release reset -> first write grant goes to client 0.
- Single write then read: client0 writes 8'hAA to addr 0, then reads addr 0 -> rf_we pulses one cycle after the request, and rd_valid[0] with rd_data=8'hAA appears two cycles after the read request.
- Contention: both clients hold wr_req for 4 cycles (c0: addr0/8'h11, c1: addr1/8'h22) -> grants alternate 0,1,0,1.
- Forwarding: register 1 holds 8'h00; c0 writes 8'hFF to addr 1 one cycle before c1 reads addr 1 -> rd_data=8'hFF, not 8'h00.
- Pipelined reads: c0 and c1 request reads of addr 0 and addr 1 continuously -> rd_valid alternates each cycle with the correct data and tags.
- Mid-operation reset: assert reset on the capture edge of a pending read -> no rd_valid pulse, rd_data=0, and both pointers return to 0.
